icache_tag_status_stage: RTL and testbench
==========================================

# icache_tag_status_stage

Parametrised first stage of the instruction-cache lookup pipeline. It holds the tag array and status array internally as flop arrays, performs a one-cycle registered read of every way's tag and status for the requested set, and carries request metadata alongside. It adds three things to the fixed 4-way stage:
- configurable geometry;
- read-during-write bypass;
- a sequenced whole-cache invalidate (flush).

The next stage consumes its outputs for tag compare and way select.

## Interface
Parameters:
- METADATA_WIDTH, 16, width of pass-through request metadata
- SET_BITS_WIDTH, 4, set index width; NUM_SETS = 2**SET_BITS_WIDTH
- NUM_WAYS, 4, associativity (>=1)
- TAG_WIDTH, 8, tag bits per way; TA_WORD_WIDTH = TAG_WIDTH*NUM_WAYS
- STATUS_WIDTH, 2, status bits per way; SA_WORD_WIDTH = STATUS_WIDTH*NUM_WAYS

Ports:
- clk  in  1  clock; all state on rising edge
- arst_n  in  1  asynchronous active-low reset
- i_halt  in  1  pipeline stall; freezes all state
- i_metadata / i_metadata_valid  in  METADATA_WIDTH / 1  request sideband
- i_r_set_addr / i_r_valid  in  SET_BITS_WIDTH / 1  read request
- i_w_ta_set_addr, i_w_ta_data, i_w_ta_mask, i_w_ta_valid  in  SET_BITS_WIDTH, TA_WORD_WIDTH, NUM_WAYS, 1  tag write; mask bit w enables way w (bits [w*TAG_WIDTH +: TAG_WIDTH])
- i_w_sa_set_addr, i_w_sa_data, i_w_sa_mask, i_w_sa_valid  in  same shape with STATUS_WIDTH/SA_WORD_WIDTH  status write
- i_flush  in  1  request invalidate of all status entries
- o_ta_data / o_ta_data_valid  out  TA_WORD_WIDTH / 1  tag read result
- o_sa_data / o_sa_data_valid  out  SA_WORD_WIDTH / 1  status read result
- o_metadata / o_metadata_valid  out  METADATA_WIDTH / 1  registered sideband
- o_flush_busy  out  1  flush sweep in progress
- o_ready  out  1  all inputs accepted this cycle

## Operation
- o_ready = ~i_halt & (state == IDLE).
- Inputs carrying valid (read, writes, flush) take effect only in cycles with o_ready=1. In other cycles they are dropped; upstream holds them.
- States: IDLE, FLUSH.
- IDLE -> FLUSH when i_flush & o_ready.
- In FLUSH, a SET_BITS_WIDTH counter starts at 0. Each non-halted cycle it writes zero to every way's status at set[counter], then increments.
- FLUSH -> IDLE on the cycle that clears set NUM_SETS-1. The counter wraps to 0.
- Tag array is never touched by flush.
- Writes: masked per way; unmasked ways keep their contents.
- Tag and status writes are independent and may target different sets in the same cycle.
- Read: on accept, o_ta_data/o_sa_data load the addressed set. The matching valid outputs load 1. On a non-halted cycle with no accepted read, the valids load 0 and the data holds.
- Metadata register loads {i_metadata, i_metadata_valid} on every non-halted cycle, including while busy.
- Read and flush in the same accepted cycle: the read returns pre-flush contents.
- Write and flush in the same accepted cycle: the write lands; the sweep later clears its status.

## Timing
- Reset: all outputs 0, except o_ready, which is 1 as soon as i_halt=0. All array entries are 0 and state is IDLE.
- Reset mid-flush aborts the sweep. Arrays zero and the block returns to IDLE.
- Read latency: 1 cycle. A request accepted at edge T is visible after edge T.
- Flush accepted at cycle T:
  - o_flush_busy=1 and o_ready=0 for cycles T+1 .. T+NUM_SETS.
  - o_ready=1 again at T+NUM_SETS+1, absent halt.
- i_halt=1: no array write, no counter advance, all output registers hold. Halt cycles extend the flush one-for-one.

## Configuration
- ICACHE_STAGE_BYPASS_EN defined: a read and a write accepted in the same cycle to the same set return the newly written value for masked ways and stored values for unmasked ways. Tag and status are bypassed independently.
- ICACHE_STAGE_BYPASS_EN undefined: a same-cycle read returns pre-write contents; the new value is visible from the next read.

## Test plan
- Reset, then read set 3 -> one cycle later o_ta_data=0, o_sa_data=0, both valids=1. Valids return to 0 the following cycle.
- Write tag set 5 data 0xAABBCCDD mask 4'b0101; next cycle read set 5 -> o_ta_data=0x00BB00DD.
- Same-cycle tag write set 2 data 0x11223344 mask 4'b1111 and read set 2 -> with BYPASS_EN o_ta_data=0x11223344; without it o_ta_data=0.
- Status write all sets 8'hFF, then i_flush -> o_flush_busy high 16 cycles, o_ready low for those cycles. Afterwards reads of sets 0 and 15 return o_sa_data=0 and tags unchanged.
- Flush with i_halt asserted 3 cycles mid-sweep -> busy lasts 19 cycles. Metadata and outputs hold during halt.
- Assert arst_n=0 at sweep counter 7 -> all outputs 0, o_flush_busy=0, o_ready=1 the cycle after release.

Source files
------------

// File: rtl/icache_tag_status_stage.sv
// -----------------------------------------------------------------------------
// icache_tag_status_stage
//
// First stage of the instruction-cache lookup pipeline. It holds the tag and
// status arrays as flop arrays and performs a one-cycle registered read of all
// ways of the requested set. Request metadata is registered alongside the read.
// It also supports per-way masked writes and a sequenced whole-cache status
// invalidate (flush sweep).
//
// Optional feature macro: ICACHE_STAGE_BYPASS_EN
//   defined   : a read and a write accepted in the same cycle to the same set
//               return the newly written value for masked ways (tag and status
//               are bypassed independently).
//   undefined : a same-cycle read returns the pre-write contents.
//
// Ports:
//   clk, arst_n             clock, asynchronous active-low reset
//   i_halt                  pipeline stall, freezes all state
//   i_metadata(_valid)      request sideband, registered every non-halted cycle
//   i_r_set_addr/i_r_valid  read request
//   i_w_ta_*                masked tag write (mask bit w -> way w)
//   i_w_sa_*                masked status write (mask bit w -> way w)
//   i_flush                 start invalidate of all status entries
//   o_ta_data(_valid)       registered tag read result
//   o_sa_data(_valid)       registered status read result
//   o_metadata(_valid)      registered sideband
//   o_flush_busy            flush sweep in progress
//   o_ready                 inputs are accepted this cycle
// -----------------------------------------------------------------------------
module icache_tag_status_stage #(
  parameter int METADATA_WIDTH = 16,
  parameter int SET_BITS_WIDTH = 4,
  parameter int NUM_WAYS       = 4,
  parameter int TAG_WIDTH      = 8,
  parameter int STATUS_WIDTH   = 2
) (
  input  logic                                clk,
  input  logic                                arst_n,
  input  logic                                i_halt,
  input  logic [METADATA_WIDTH-1:0]           i_metadata,
  input  logic                                i_metadata_valid,
  input  logic [SET_BITS_WIDTH-1:0]           i_r_set_addr,
  input  logic                                i_r_valid,
  input  logic [SET_BITS_WIDTH-1:0]           i_w_ta_set_addr,
  input  logic [TAG_WIDTH*NUM_WAYS-1:0]       i_w_ta_data,
  input  logic [NUM_WAYS-1:0]                 i_w_ta_mask,
  input  logic                                i_w_ta_valid,
  input  logic [SET_BITS_WIDTH-1:0]           i_w_sa_set_addr,
  input  logic [STATUS_WIDTH*NUM_WAYS-1:0]    i_w_sa_data,
  input  logic [NUM_WAYS-1:0]                 i_w_sa_mask,
  input  logic                                i_w_sa_valid,
  input  logic                                i_flush,
  output logic [TAG_WIDTH*NUM_WAYS-1:0]       o_ta_data,
  output logic                                o_ta_data_valid,
  output logic [STATUS_WIDTH*NUM_WAYS-1:0]    o_sa_data,
  output logic                                o_sa_data_valid,
  output logic [METADATA_WIDTH-1:0]           o_metadata,
  output logic                                o_metadata_valid,
  output logic                                o_flush_busy,
  output logic                                o_ready
);

  localparam int NUM_SETS      = 2 ** SET_BITS_WIDTH;
  localparam int TA_WORD_WIDTH = TAG_WIDTH * NUM_WAYS;
  localparam int SA_WORD_WIDTH = STATUS_WIDTH * NUM_WAYS;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_FLUSH = 1'b1;

  localparam logic [SET_BITS_WIDTH-1:0] LAST_SET = SET_BITS_WIDTH'(NUM_SETS - 1);

  logic [0:0]                r_state;
  logic [SET_BITS_WIDTH-1:0] r_flush_cnt;

  logic [TA_WORD_WIDTH-1:0]  r_ta_mem [NUM_SETS];
  logic [SA_WORD_WIDTH-1:0]  r_sa_mem [NUM_SETS];

  logic [TA_WORD_WIDTH-1:0]  r_ta_data;
  logic                      r_ta_data_valid;
  logic [SA_WORD_WIDTH-1:0]  r_sa_data;
  logic                      r_sa_data_valid;
  logic [METADATA_WIDTH-1:0] r_metadata;
  logic                      r_metadata_valid;

  logic                      w_ready;
  logic                      w_flushing;
  logic                      w_rd_acc;
  logic                      w_ta_wr;
  logic                      w_sa_wr;
  logic [TA_WORD_WIDTH-1:0]  w_ta_bitmask;
  logic [SA_WORD_WIDTH-1:0]  w_sa_bitmask;
  logic [TA_WORD_WIDTH-1:0]  w_ta_merged;
  logic [SA_WORD_WIDTH-1:0]  w_sa_merged;
  logic [TA_WORD_WIDTH-1:0]  w_ta_rd;
  logic [SA_WORD_WIDTH-1:0]  w_sa_rd;

  assign w_ready    = ~i_halt & (r_state == ST_IDLE);
  assign w_flushing = ~i_halt & (r_state == ST_FLUSH);
  assign w_rd_acc   = w_ready & i_r_valid;
  assign w_ta_wr    = w_ready & i_w_ta_valid;
  assign w_sa_wr    = w_ready & i_w_sa_valid;

  // Expand the per-way masks to per-bit masks.
  // NOTE: every variable written in an always_comb gets a default first so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    w_ta_bitmask = '0;
    w_sa_bitmask = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      w_ta_bitmask[w*TAG_WIDTH +: TAG_WIDTH]       = {TAG_WIDTH{i_w_ta_mask[w]}};
      w_sa_bitmask[w*STATUS_WIDTH +: STATUS_WIDTH] = {STATUS_WIDTH{i_w_sa_mask[w]}};
    end
  end

  // New contents of the written set: masked ways take the write data,
  // unmasked ways keep what is stored.
  assign w_ta_merged = (r_ta_mem[i_w_ta_set_addr] & ~w_ta_bitmask) | (i_w_ta_data & w_ta_bitmask);
  assign w_sa_merged = (r_sa_mem[i_w_sa_set_addr] & ~w_sa_bitmask) | (i_w_sa_data & w_sa_bitmask);

`ifdef ICACHE_STAGE_BYPASS_EN
  // Same-set write in the read cycle: forward the merged word instead of the
  // stale array contents. Tag and status are forwarded independently.
  assign w_ta_rd = (w_ta_wr && (i_w_ta_set_addr == i_r_set_addr)) ? w_ta_merged
                                                                  : r_ta_mem[i_r_set_addr];
  assign w_sa_rd = (w_sa_wr && (i_w_sa_set_addr == i_r_set_addr)) ? w_sa_merged
                                                                  : r_sa_mem[i_r_set_addr];
`else
  assign w_ta_rd = r_ta_mem[i_r_set_addr];
  assign w_sa_rd = r_sa_mem[i_r_set_addr];
`endif

  // Control: IDLE <-> FLUSH sweep. The counter ends at 0 again after the last
  // set because it naturally wraps.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_state     <= ST_IDLE;
      r_flush_cnt <= '0;
    end else if (w_flushing) begin
      r_flush_cnt <= r_flush_cnt + 1'b1;
      if (r_flush_cnt == LAST_SET) r_state <= ST_IDLE;
    end else if (w_ready && i_flush) begin
      r_state <= ST_FLUSH;
    end
  end

  // Arrays. Writes are only accepted in IDLE, so the sweep clear and a status
  // write never compete for the same cycle.
  // NOTE: the arrays are reset because their contents are architecturally
  // visible as zero after reset (and after an aborted sweep).
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        r_ta_mem[s] <= '0;
        r_sa_mem[s] <= '0;
      end
    end else begin
      if (w_ta_wr) r_ta_mem[i_w_ta_set_addr] <= w_ta_merged;
      if (w_flushing)   r_sa_mem[r_flush_cnt]     <= '0;
      else if (w_sa_wr) r_sa_mem[i_w_sa_set_addr] <= w_sa_merged;
    end
  end

  // Output registers: everything holds while halted. Read data holds when no
  // read is accepted; only the valids drop.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_ta_data        <= '0;
      r_ta_data_valid  <= 1'b0;
      r_sa_data        <= '0;
      r_sa_data_valid  <= 1'b0;
      r_metadata       <= '0;
      r_metadata_valid <= 1'b0;
    end else if (!i_halt) begin
      r_metadata       <= i_metadata;
      r_metadata_valid <= i_metadata_valid;
      r_ta_data_valid  <= w_rd_acc;
      r_sa_data_valid  <= w_rd_acc;
      if (w_rd_acc) begin
        r_ta_data <= w_ta_rd;
        r_sa_data <= w_sa_rd;
      end
    end
  end

  assign o_ta_data        = r_ta_data;
  assign o_ta_data_valid  = r_ta_data_valid;
  assign o_sa_data        = r_sa_data;
  assign o_sa_data_valid  = r_sa_data_valid;
  assign o_metadata       = r_metadata;
  assign o_metadata_valid = r_metadata_valid;
  assign o_flush_busy     = (r_state == ST_FLUSH);
  assign o_ready          = w_ready;

endmodule

// File: tb/tb_icache_tag_status_stage.sv
// -----------------------------------------------------------------------------
// tb_icache_tag_status_stage
//
// Self-checking bench for icache_tag_status_stage (default geometry: 16 sets,
// 4 ways, 8-bit tags, 2-bit status). A directed vector table covers the basic
// read/write cases, hand sequences cover flush, halt-during-flush and reset
// mid-flush, and a randomized phase is compared against a behavioural model.
// -----------------------------------------------------------------------------
module tb_icache_tag_status_stage;

  localparam int NSETS = 16;
  localparam int NWAYS = 4;

  logic        clk;
  logic        arst_n;
  logic        i_halt;
  logic [15:0] i_metadata;
  logic        i_metadata_valid;
  logic [3:0]  i_r_set_addr;
  logic        i_r_valid;
  logic [3:0]  i_w_ta_set_addr;
  logic [31:0] i_w_ta_data;
  logic [3:0]  i_w_ta_mask;
  logic        i_w_ta_valid;
  logic [3:0]  i_w_sa_set_addr;
  logic [7:0]  i_w_sa_data;
  logic [3:0]  i_w_sa_mask;
  logic        i_w_sa_valid;
  logic        i_flush;
  logic [31:0] o_ta_data;
  logic        o_ta_data_valid;
  logic [7:0]  o_sa_data;
  logic        o_sa_data_valid;
  logic [15:0] o_metadata;
  logic        o_metadata_valid;
  logic        o_flush_busy;
  logic        o_ready;

  icache_tag_status_stage dut (
    .clk              (clk),
    .arst_n           (arst_n),
    .i_halt           (i_halt),
    .i_metadata       (i_metadata),
    .i_metadata_valid (i_metadata_valid),
    .i_r_set_addr     (i_r_set_addr),
    .i_r_valid        (i_r_valid),
    .i_w_ta_set_addr  (i_w_ta_set_addr),
    .i_w_ta_data      (i_w_ta_data),
    .i_w_ta_mask      (i_w_ta_mask),
    .i_w_ta_valid     (i_w_ta_valid),
    .i_w_sa_set_addr  (i_w_sa_set_addr),
    .i_w_sa_data      (i_w_sa_data),
    .i_w_sa_mask      (i_w_sa_mask),
    .i_w_sa_valid     (i_w_sa_valid),
    .i_flush          (i_flush),
    .o_ta_data        (o_ta_data),
    .o_ta_data_valid  (o_ta_data_valid),
    .o_sa_data        (o_sa_data),
    .o_sa_data_valid  (o_sa_data_valid),
    .o_metadata       (o_metadata),
    .o_metadata_valid (o_metadata_valid),
    .o_flush_busy     (o_flush_busy),
    .o_ready          (o_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model: plain arrays plus a count of sets still to be cleared.
  logic [31:0] m_ta [NSETS];
  logic [7:0]  m_sa [NSETS];
  int          m_fl_left;
  int          m_fl_idx;
  logic [31:0] e_ta;
  logic        e_ta_v;
  logic [7:0]  e_sa;
  logic        e_sa_v;
  logic [15:0] e_meta;
  logic        e_meta_v;

  typedef struct {
    logic        r_v;   logic [3:0] r_set;
    logic        ta_v;  logic [3:0] ta_set; logic [31:0] ta_data; logic [3:0] ta_mask;
    logic        sa_v;  logic [3:0] sa_set; logic [7:0]  sa_data; logic [3:0] sa_mask;
    logic [15:0] meta;  logic       meta_v;
    logic [31:0] x_ta;  logic       x_ta_v; logic [7:0]  x_sa;    logic       x_sa_v;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < NSETS; s++) begin
      m_ta[s] = '0;
      m_sa[s] = '0;
    end
    m_fl_left = 0;
    m_fl_idx  = 0;
    e_ta = '0; e_ta_v = 1'b0; e_sa = '0; e_sa_v = 1'b0;
    e_meta = '0; e_meta_v = 1'b0;
  endtask

  // Advance the model by one clock edge using the currently driven inputs.
  task automatic model_step();
    logic [31:0] rt;
    logic [7:0]  rs;
    if (i_halt) return;
    e_meta   = i_metadata;
    e_meta_v = i_metadata_valid;
    if (m_fl_left > 0) begin
      m_sa[m_fl_idx] = '0;
      m_fl_idx++;
      m_fl_left--;
      e_ta_v = 1'b0;
      e_sa_v = 1'b0;
    end else begin
      rt = m_ta[i_r_set_addr];
      rs = m_sa[i_r_set_addr];
`ifdef ICACHE_STAGE_BYPASS_EN
      for (int w = 0; w < NWAYS; w++) begin
        if (i_w_ta_valid && i_w_ta_set_addr == i_r_set_addr && i_w_ta_mask[w])
          rt[w*8 +: 8] = i_w_ta_data[w*8 +: 8];
        if (i_w_sa_valid && i_w_sa_set_addr == i_r_set_addr && i_w_sa_mask[w])
          rs[w*2 +: 2] = i_w_sa_data[w*2 +: 2];
      end
`endif
      if (i_r_valid) begin
        e_ta = rt;
        e_sa = rs;
      end
      e_ta_v = i_r_valid;
      e_sa_v = i_r_valid;
      for (int w = 0; w < NWAYS; w++) begin
        if (i_w_ta_valid && i_w_ta_mask[w]) m_ta[i_w_ta_set_addr][w*8 +: 8] = i_w_ta_data[w*8 +: 8];
        if (i_w_sa_valid && i_w_sa_mask[w]) m_sa[i_w_sa_set_addr][w*2 +: 2] = i_w_sa_data[w*2 +: 2];
      end
      if (i_flush) begin
        m_fl_left = NSETS;
        m_fl_idx  = 0;
      end
    end
  endtask

  task automatic set_idle();
    i_halt = 1'b0; i_metadata = '0; i_metadata_valid = 1'b0;
    i_r_valid = 1'b0; i_r_set_addr = '0;
    i_w_ta_valid = 1'b0; i_w_ta_set_addr = '0; i_w_ta_data = '0; i_w_ta_mask = '0;
    i_w_sa_valid = 1'b0; i_w_sa_set_addr = '0; i_w_sa_data = '0; i_w_sa_mask = '0;
    i_flush = 1'b0;
  endtask

  // One clock cycle with the inputs already driven; compares everything.
  task automatic step();
    #1;
    check("o_ready", o_ready, (!i_halt && m_fl_left == 0));
    model_step();
    @(posedge clk);
    #1;
    check("o_ta_data",        o_ta_data,        e_ta);
    check("o_ta_data_valid",  o_ta_data_valid,  e_ta_v);
    check("o_sa_data",        o_sa_data,        e_sa);
    check("o_sa_data_valid",  o_sa_data_valid,  e_sa_v);
    check("o_metadata",       o_metadata,       e_meta);
    check("o_metadata_valid", o_metadata_valid, e_meta_v);
    check("o_flush_busy",     o_flush_busy,     (m_fl_left > 0));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " ta"},     o_ta_data,        0);
    check({tag, " ta_v"},   o_ta_data_valid,  0);
    check({tag, " sa"},     o_sa_data,        0);
    check({tag, " sa_v"},   o_sa_data_valid,  0);
    check({tag, " meta"},   o_metadata,       0);
    check({tag, " meta_v"}, o_metadata_valid, 0);
    check({tag, " busy"},   o_flush_busy,     0);
    check({tag, " ready"},  o_ready,          1);
  endtask

  task automatic read_set(input logic [3:0] s);
    set_idle();
    i_r_valid = 1'b1;
    i_r_set_addr = s;
    step();
  endtask

  // Steps idle cycles while busy; halts cycles [h_from, h_to) of the sweep.
  task automatic count_busy(input int h_from, input int h_to, output int n);
    n = 0;
    while (o_flush_busy && n < 100) begin
      set_idle();
      i_halt = (n >= h_from && n < h_to);
      i_metadata = 16'(n + 16'h4000);
      i_metadata_valid = 1'b1;
      n++;
      step();
    end
    set_idle();
  endtask

  initial begin
    int n;

    vecs[0] = '{1, 3, 0, 0, 32'h0, 4'h0, 0, 0, 8'h0, 4'h0, 16'h1234, 1, 32'h0, 1, 8'h0, 1};
    vecs[1] = '{0, 0, 0, 0, 32'h0, 4'h0, 0, 0, 8'h0, 4'h0, 16'h0000, 0, 32'h0, 0, 8'h0, 0};
    vecs[2] = '{0, 0, 1, 5, 32'hAABBCCDD, 4'h5, 0, 0, 8'h0, 4'h0, 16'h5555, 1, 32'h0, 0, 8'h0, 0};
    vecs[3] = '{1, 5, 0, 0, 32'h0, 4'h0, 0, 0, 8'h0, 4'h0, 16'hBEEF, 1, 32'h00BB00DD, 1, 8'h0, 1};
`ifdef ICACHE_STAGE_BYPASS_EN
    vecs[4] = '{1, 2, 1, 2, 32'h11223344, 4'hF, 0, 0, 8'h0, 4'h0, 16'h0002, 0, 32'h11223344, 1, 8'h0, 1};
`else
    vecs[4] = '{1, 2, 1, 2, 32'h11223344, 4'hF, 0, 0, 8'h0, 4'h0, 16'h0002, 0, 32'h00000000, 1, 8'h0, 1};
`endif
    vecs[5] = '{1, 2, 0, 0, 32'h0, 4'h0, 0, 0, 8'h0, 4'h0, 16'h0003, 1, 32'h11223344, 1, 8'h0, 1};
    vecs[6] = '{0, 0, 0, 0, 32'h0, 4'h0, 1, 7, 8'hFF, 4'h6, 16'h0006, 1, 32'h11223344, 0, 8'h0, 0};
    vecs[7] = '{1, 7, 0, 0, 32'h0, 4'h0, 0, 0, 8'h0, 4'h0, 16'h0007, 1, 32'h0, 1, 8'h3C, 1};

    // Reset
    set_idle();
    model_reset();
    arst_n = 1'b0;
    #3;
    check_reset_outputs("reset");
    #9 arst_n = 1'b1;
    step();

    // Directed vector table
    for (int i = 0; i < 8; i++) begin
      set_idle();
      i_r_valid = vecs[i].r_v;     i_r_set_addr = vecs[i].r_set;
      i_w_ta_valid = vecs[i].ta_v; i_w_ta_set_addr = vecs[i].ta_set;
      i_w_ta_data = vecs[i].ta_data; i_w_ta_mask = vecs[i].ta_mask;
      i_w_sa_valid = vecs[i].sa_v; i_w_sa_set_addr = vecs[i].sa_set;
      i_w_sa_data = vecs[i].sa_data; i_w_sa_mask = vecs[i].sa_mask;
      i_metadata = vecs[i].meta;   i_metadata_valid = vecs[i].meta_v;
      step();
      check($sformatf("vec%0d ta", i),     o_ta_data,        vecs[i].x_ta);
      check($sformatf("vec%0d ta_v", i),   o_ta_data_valid,  vecs[i].x_ta_v);
      check($sformatf("vec%0d sa", i),     o_sa_data,        vecs[i].x_sa);
      check($sformatf("vec%0d sa_v", i),   o_sa_data_valid,  vecs[i].x_sa_v);
      check($sformatf("vec%0d meta", i),   o_metadata,       vecs[i].meta);
      check($sformatf("vec%0d meta_v", i), o_metadata_valid, vecs[i].meta_v);
    end

    // Fill status with all ones, tag sets 0 and 15, then flush
    for (int s = 0; s < NSETS; s++) begin
      set_idle();
      i_w_sa_valid = 1'b1; i_w_sa_set_addr = 4'(s); i_w_sa_data = 8'hFF; i_w_sa_mask = 4'hF;
      i_w_ta_valid = (s == 0 || s == 15);
      i_w_ta_set_addr = 4'(s);
      i_w_ta_data = (s == 0) ? 32'hDEADBEEF : 32'h0BADF00D;
      i_w_ta_mask = 4'hF;
      step();
    end
    set_idle();
    i_flush = 1'b1;
    step();
    count_busy(0, 0, n);
    check("flush busy cycles", 64'(n), 64'd16);
    read_set(4'd0);
    check("post-flush sa0", o_sa_data, 8'h00);
    check("post-flush ta0", o_ta_data, 32'hDEADBEEF);
    read_set(4'd15);
    check("post-flush sa15", o_sa_data, 8'h00);
    check("post-flush ta15", o_ta_data, 32'h0BADF00D);
    read_set(4'd5);
    check("post-flush ta5", o_ta_data, 32'h00BB00DD);

    // Flush with a 3-cycle halt mid-sweep
    set_idle();
    i_w_sa_valid = 1'b1; i_w_sa_set_addr = 4'd9; i_w_sa_data = 8'hA5; i_w_sa_mask = 4'hF;
    i_flush = 1'b1;
    step();
    count_busy(5, 8, n);
    check("halted flush busy cycles", 64'(n), 64'd19);
    read_set(4'd9);
    check("halted flush sa9", o_sa_data, 8'h00);

    // Reset while the sweep counter is at 7
    set_idle();
    i_w_ta_valid = 1'b1; i_w_ta_set_addr = 4'd9; i_w_ta_data = 32'hCAFEF00D; i_w_ta_mask = 4'hF;
    i_flush = 1'b1;
    step();
    for (int k = 0; k < 7; k++) begin
      set_idle();
      step();
    end
    arst_n = 1'b0;
    #1;
    check_reset_outputs("mid-flush reset");
    model_reset();
    #3 arst_n = 1'b1;
    set_idle();
    step();
    check("after reset ready-cycle busy", o_flush_busy, 0);
    read_set(4'd9);
    check("after reset ta9", o_ta_data, 32'h0);
    read_set(4'd5);
    check("after reset ta5", o_ta_data, 32'h0);

    // Randomized traffic against the model
    for (int c = 0; c < 600; c++) begin
      i_halt           = ($urandom_range(0, 7) == 0);
      i_metadata       = 16'($urandom);
      i_metadata_valid = 1'($urandom_range(0, 1));
      i_r_valid        = 1'($urandom_range(0, 1));
      i_r_set_addr     = 4'($urandom_range(0, 15));
      i_w_ta_valid     = 1'($urandom_range(0, 1));
      i_w_ta_set_addr  = ($urandom_range(0, 3) == 0) ? i_r_set_addr : 4'($urandom_range(0, 15));
      i_w_ta_data      = $urandom;
      i_w_ta_mask      = 4'($urandom);
      i_w_sa_valid     = 1'($urandom_range(0, 1));
      i_w_sa_set_addr  = ($urandom_range(0, 3) == 0) ? i_r_set_addr : 4'($urandom_range(0, 15));
      i_w_sa_data      = 8'($urandom);
      i_w_sa_mask      = 4'($urandom);
      i_flush          = ($urandom_range(0, 39) == 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
